// File: rtl/radar_chirp_pkg.sv
// Shared definitions for the chirp DDS sequencer: FSM encoding, parameter-word layout
// and the power-up chirp defaults.
package radar_chirp_pkg;

    localparam logic [2:0] ST_STARTUP = 3'd0;
    localparam logic [2:0] ST_READY   = 3'd1;
    localparam logic [2:0] ST_CHIRP   = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_HOLDOFF = 3'd4;

    localparam int CP_FIELD_W     = 32;
    localparam int CP_COUNTER_MAX = 0;
    localparam int CP_TUNING_COEF = 32;
    localparam int CP_FREQ_OFFSET = 64;

    localparam logic [31:0] DEF_COUNTER_MAX = 32'h0000_0fff;
    localparam logic [31:0] DEF_TUNING_COEF = 32'h0000_0001;
    localparam logic [31:0] DEF_FREQ_OFFSET = 32'h0000_0600;

    typedef struct packed {
        logic [31:0] freq_offset;
        logic [31:0] tuning_coef;
        logic [31:0] counter_max;
    } chirp_params_t;

    function automatic chirp_params_t unpack_chirp_params(input logic [95:0] raw);
        chirp_params_t p;
        p.freq_offset = raw[CP_FREQ_OFFSET +: CP_FIELD_W];
        p.tuning_coef = raw[CP_TUNING_COEF +: CP_FIELD_W];
        p.counter_max = raw[CP_COUNTER_MAX +: CP_FIELD_W];
        return p;
    endfunction

endpackage

// File: rtl/chirp_phase_accum.sv
// Sample counter, linear-FM ramp and shadow copy of the chirp parameters.
// phase is the registered DDS increment; it reads 0 whenever neither load nor step is asserted.
module chirp_phase_accum
    import radar_chirp_pkg::*;
(
    input  logic          clk_fmc150,
    input  logic          resetn_fmc150,
    input  logic          load,
    input  logic          step,
    input  chirp_params_t params,
    output logic          last,
    output logic [31:0]   phase
);

    chirp_params_t shadow;
    logic [31:0]   sample_idx;
    logic [31:0]   ramp;

    // ramp runs one sample ahead (i*tuning_coef for the next sample) so phase stays a plain register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_fmc150 or negedge resetn_fmc150) begin
        if (!resetn_fmc150) begin
            shadow     <= '{freq_offset: DEF_FREQ_OFFSET,
                            tuning_coef: DEF_TUNING_COEF,
                            counter_max: DEF_COUNTER_MAX};
            sample_idx <= '0;
            ramp       <= '0;
            phase      <= '0;
        end else if (load) begin
            shadow     <= params;
            sample_idx <= '0;
            ramp       <= params.tuning_coef;
            phase      <= params.freq_offset;
        end else if (step) begin
            sample_idx <= sample_idx + 32'd1;
            ramp       <= ramp + shadow.tuning_coef;
            phase      <= shadow.freq_offset + ramp;
        end else begin
            sample_idx <= '0;
            ramp       <= '0;
            phase      <= '0;
        end
    end

    assign last = (sample_idx == shadow.counter_max);

endmodule

// File: rtl/chirp_dds_sequencer.sv
// Chirp handshake responder in the clk_fmc150 DAC domain: FSM, startup/holdoff timing and
// registered handshake outputs around the phase-increment generator.
module chirp_dds_sequencer
    import radar_chirp_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 4,
    parameter int STARTUP_CYCLES = 16
) (
    input  logic         clk_fmc150,
    input  logic         resetn_fmc150,
    input  logic         dac_ready,
    input  logic [127:0] chirp_parameters_in,
    input  logic         chirp_init,
    input  logic         chirp_enable,
    output logic         chirp_ready,
    output logic         chirp_active,
    output logic         chirp_done,
    output logic         chirp_aborted,
    output logic [31:0]  dds_phase_inc,
    output logic         dds_valid
);

    localparam int SW = $clog2(STARTUP_CYCLES + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    logic [2:0]    state, state_nxt;
    logic [SW-1:0] startup_cnt;
    logic [HW-1:0] holdoff_cnt;
    logic          accept, abort, last, load, step;
    logic          startup_done, holdoff_done;
    chirp_params_t params;
    logic          unused_upper;

    assign unused_upper = ^chirp_parameters_in[127:96];
    assign params       = unpack_chirp_params(chirp_parameters_in[95:0]);
    assign accept       = chirp_init & chirp_enable & dac_ready;
    assign abort        = ~chirp_enable | ~dac_ready;
    assign startup_done = (startup_cnt == SW'(STARTUP_CYCLES));
    assign holdoff_done = (holdoff_cnt == HW'(HOLDOFF_CYCLES - 1));

    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STARTUP: if (dac_ready && startup_done) state_nxt = ST_READY;
            ST_READY: begin
                if (!dac_ready)  state_nxt = ST_STARTUP;
                else if (accept) state_nxt = ST_CHIRP;
            end
            ST_CHIRP:   if (last || abort) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_HOLDOFF;
            ST_HOLDOFF: if (holdoff_done) state_nxt = dac_ready ? ST_READY : ST_STARTUP;
            default:    state_nxt = ST_STARTUP;
        endcase
    end

    assign load = (state == ST_READY) && (state_nxt == ST_CHIRP);
    assign step = (state == ST_CHIRP) && (state_nxt == ST_CHIRP);

    // Handshake outputs are registered from the next state so they line up with the new state.
    always_ff @(posedge clk_fmc150 or negedge resetn_fmc150) begin
        if (!resetn_fmc150) begin
            state         <= ST_STARTUP;
            startup_cnt   <= '0;
            holdoff_cnt   <= '0;
            chirp_ready   <= 1'b0;
            chirp_active  <= 1'b0;
            chirp_done    <= 1'b0;
            chirp_aborted <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_STARTUP && dac_ready && !startup_done)
                startup_cnt <= startup_cnt + 1'b1;
            else
                startup_cnt <= '0;
            if (state == ST_HOLDOFF)
                holdoff_cnt <= holdoff_cnt + 1'b1;
            else
                holdoff_cnt <= '0;
            chirp_ready   <= (state_nxt == ST_READY) && dac_ready;
            chirp_active  <= (state_nxt == ST_CHIRP);
            chirp_done    <= (state_nxt == ST_DONE);
            // A cut-short chirp whose last sample coincides with the abort counts as complete.
            chirp_aborted <= (state == ST_CHIRP) && !last && abort;
        end
    end

    assign dds_valid = chirp_active;

    chirp_phase_accum u_phase_accum (
        .clk_fmc150    (clk_fmc150),
        .resetn_fmc150 (resetn_fmc150),
        .load          (load),
        .step          (step),
        .params        (params),
        .last          (last),
        .phase         (dds_phase_inc)
    );

endmodule

// File: tb/tb_chirp_dds_sequencer.sv
// Scoreboard bench for chirp_dds_sequencer: stimulus pushes expected samples, done pulses and
// chirp_ready rises (tagged with cycle numbers); a negedge monitor pops and compares.
module tb_chirp_dds_sequencer;

    logic         clk_fmc150 = 1'b0;
    logic         resetn_fmc150 = 1'b0;
    logic         dac_ready = 1'b0;
    logic [127:0] chirp_parameters_in = '0;
    logic         chirp_init = 1'b0;
    logic         chirp_enable = 1'b0;
    logic         chirp_ready, chirp_active, chirp_done, chirp_aborted, dds_valid;
    logic [31:0]  dds_phase_inc;

    chirp_dds_sequencer #(.HOLDOFF_CYCLES(4), .STARTUP_CYCLES(16)) dut (
        .clk_fmc150          (clk_fmc150),
        .resetn_fmc150       (resetn_fmc150),
        .dac_ready           (dac_ready),
        .chirp_parameters_in (chirp_parameters_in),
        .chirp_init          (chirp_init),
        .chirp_enable        (chirp_enable),
        .chirp_ready         (chirp_ready),
        .chirp_active        (chirp_active),
        .chirp_done          (chirp_done),
        .chirp_aborted       (chirp_aborted),
        .dds_phase_inc       (dds_phase_inc),
        .dds_valid           (dds_valid)
    );

    always #2 clk_fmc150 = ~clk_fmc150;

    // cyc = number of rising edges so far; an output seen at a negedge belongs to edge cyc.
    int cyc = 0;
    always @(posedge clk_fmc150) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct { int cyc; logic [31:0] phase; } sample_t;
    typedef struct { int cyc; bit aborted; } done_t;

    sample_t exp_sample_q[$];
    done_t   exp_done_q[$];
    int      exp_ready_q[$];
    logic    prev_ready = 1'b0;
    sample_t mon_s;
    done_t   mon_d;
    int      mon_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_s(input int c, input logic [31:0] p);
        exp_sample_q.push_back('{cyc: c, phase: p});
    endtask

    task automatic exp_d(input int c, input bit ab);
        exp_done_q.push_back('{cyc: c, aborted: ab});
    endtask

    task automatic exp_r(input int c);
        exp_ready_q.push_back(c);
    endtask

    always @(negedge clk_fmc150) begin
        if (resetn_fmc150) begin
            check("active_eq_valid", 32'(chirp_active), 32'(dds_valid));
            if (dds_valid) begin
                tests++;
                if (exp_sample_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_sample: phase 0x%08h at cycle %0d, none expected", dds_phase_inc, cyc);
                end else begin
                    mon_s = exp_sample_q.pop_front();
                    check("sample_cycle", cyc, mon_s.cyc);
                    check("sample_phase", dds_phase_inc, mon_s.phase);
                end
            end else begin
                check("idle_phase", dds_phase_inc, 32'h0);
            end
            if (chirp_done) begin
                tests++;
                if (exp_done_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: at cycle %0d, none expected", cyc);
                end else begin
                    mon_d = exp_done_q.pop_front();
                    check("done_cycle", cyc, mon_d.cyc);
                    check("done_aborted", 32'(chirp_aborted), 32'(mon_d.aborted));
                end
            end else begin
                check("aborted_without_done", 32'(chirp_aborted), 32'h0);
            end
            if (chirp_ready && !prev_ready) begin
                tests++;
                if (exp_ready_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ready: rise at cycle %0d, none expected", cyc);
                end else begin
                    mon_r = exp_ready_q.pop_front();
                    check("ready_cycle", cyc, mon_r);
                end
            end
            prev_ready = chirp_ready;
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk_fmc150);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!chirp_ready && t < 300) begin
            @(negedge clk_fmc150);
            t++;
        end
        tests++;
        if (!chirp_ready) begin
            fails++;
            $display("FAIL ready_timeout: chirp_ready still 0 after %0d cycles (cycle %0d)", t, cyc);
        end
    endtask

    // Called at a negedge; the accept is sampled on the next rising edge, numbered k.
    task automatic start_accept(input logic [31:0] fo, input logic [31:0] tc,
                                input logic [31:0] cm, output int k);
        chirp_parameters_in = {32'h0, fo, tc, cm};
        chirp_init   = 1'b1;
        chirp_enable = 1'b1;
        k = cyc + 1;
    endtask

    task automatic finish_accept();
        @(negedge clk_fmc150);
        chirp_init = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},   32'(chirp_ready),   32'h0);
        check({tag, "_active"},  32'(chirp_active),  32'h0);
        check({tag, "_done"},    32'(chirp_done),    32'h0);
        check({tag, "_aborted"}, 32'(chirp_aborted), 32'h0);
        check({tag, "_valid"},   32'(dds_valid),     32'h0);
        check({tag, "_phase"},   dds_phase_inc,      32'h0);
    endtask

    initial begin
        int k;

        // Reset state and startup latency (17 edges after release).
        dac_ready = 1'b1;
        repeat (3) @(negedge clk_fmc150);
        check_all_zero("reset");
        resetn_fmc150 = 1'b1;
        exp_r(cyc + 17);
        wait_ready();

        // Basic 4-sample chirp.
        start_accept(32'h0000_0600, 32'h1, 32'h3, k);
        exp_s(k, 32'h600); exp_s(k+1, 32'h601); exp_s(k+2, 32'h602); exp_s(k+3, 32'h603);
        exp_d(k+4, 1'b0);
        exp_r(k+9);
        finish_accept();
        wait_ready();

        // 32-bit wrap of the phase increment.
        start_accept(32'hFFFF_FFFE, 32'h1, 32'h3, k);
        exp_s(k, 32'hFFFF_FFFE); exp_s(k+1, 32'hFFFF_FFFF); exp_s(k+2, 32'h0); exp_s(k+3, 32'h1);
        exp_d(k+4, 1'b0);
        exp_r(k+9);
        finish_accept();
        wait_ready();

        // Single-sample chirp.
        start_accept(32'h0000_1234, 32'h55, 32'h0, k);
        exp_s(k, 32'h1234);
        exp_d(k+1, 1'b0);
        exp_r(k+6);
        finish_accept();
        wait_ready();

        // chirp_enable dropped during sample 2 of a 4096-sample chirp.
        start_accept(32'h0000_0600, 32'h1, 32'h0000_0fff, k);
        exp_s(k, 32'h600); exp_s(k+1, 32'h601); exp_s(k+2, 32'h602);
        exp_d(k+3, 1'b1);
        exp_r(k+8);
        finish_accept();
        wait_cyc(k+2);
        chirp_enable = 1'b0;
        wait_ready();
        chirp_enable = 1'b1;

        // dac_ready dropped mid-chirp: abort, then full startup once it returns.
        start_accept(32'h0000_0100, 32'h2, 32'h0000_00ff, k);
        exp_s(k, 32'h100); exp_s(k+1, 32'h102);
        exp_d(k+2, 1'b1);
        finish_accept();
        wait_cyc(k+1);
        dac_ready = 1'b0;
        wait_cyc(k+10);
        dac_ready = 1'b1;
        exp_r(k+27);
        wait_ready();

        // Parameter change mid-chirp, init pulses in CHIRP and HOLDOFF ignored.
        start_accept(32'h0000_2000, 32'h10, 32'h3, k);
        exp_s(k, 32'h2000); exp_s(k+1, 32'h2010); exp_s(k+2, 32'h2020); exp_s(k+3, 32'h2030);
        exp_d(k+4, 1'b0);
        exp_r(k+9);
        finish_accept();
        wait_cyc(k+1);
        chirp_parameters_in = {32'h0, 32'h0000_9000, 32'h3, 32'h1};
        wait_cyc(k+2);
        chirp_init = 1'b1;
        @(negedge clk_fmc150);
        chirp_init = 1'b0;
        wait_cyc(k+6);
        chirp_init = 1'b1;
        @(negedge clk_fmc150);
        chirp_init = 1'b0;
        wait_ready();

        // init without enable in READY is ignored and chirp_ready stays up.
        chirp_enable = 1'b0;
        chirp_init   = 1'b1;
        @(negedge clk_fmc150);
        chirp_init = 1'b0;
        repeat (6) @(negedge clk_fmc150);
        check("ready_kept_after_ignored_init", 32'(chirp_ready), 32'h1);

        // Next accept picks up the parameters written during the previous chirp.
        chirp_enable = 1'b1;
        chirp_init   = 1'b1;
        k = cyc + 1;
        exp_s(k, 32'h9000); exp_s(k+1, 32'h9003);
        exp_d(k+2, 1'b0);
        exp_r(k+7);
        finish_accept();
        wait_ready();

        // Reset mid-chirp clears everything immediately with no done pulse.
        start_accept(32'h0000_0700, 32'h1, 32'h0000_00ff, k);
        exp_s(k, 32'h700); exp_s(k+1, 32'h701);
        finish_accept();
        wait_cyc(k+1);
        #1 resetn_fmc150 = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk_fmc150);
        resetn_fmc150 = 1'b1;
        exp_r(cyc + 17);
        wait_ready();

        repeat (10) @(negedge clk_fmc150);
        check("samples_left", exp_sample_q.size(), 32'h0);
        check("dones_left",   exp_done_q.size(),   32'h0);
        check("readys_left",  exp_ready_q.size(),  32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
